// File: rtl/fpnew_noncomp_outpipe_if.sv
// Handshake and data bundle between the non-computational FP unit, its retirement pipe and the consumer.
// Optional macro FPNEW_NONCOMP_STICKY_FLAGS_EN adds the sticky-flag clear/readout pair.
interface fpnew_noncomp_outpipe_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned TagWidth = 1,
  parameter int unsigned AuxWidth = 1
);
  logic [WIDTH-1:0]    result_i;
  logic [4:0]          status_i;
  logic                extension_bit_i;
  logic [9:0]          class_mask_i;
  logic                is_class_i;
  logic [TagWidth-1:0] tag_i;
  logic [AuxWidth-1:0] aux_i;
  logic                in_valid_i;
  logic                in_ready_o;
  logic                flush_i;
  logic [WIDTH-1:0]    result_o;
  logic [4:0]          status_o;
  logic                extension_bit_o;
  logic [TagWidth-1:0] tag_o;
  logic [AuxWidth-1:0] aux_o;
  logic                out_valid_o;
  logic                out_ready_i;
  logic                busy_o;
`ifdef FPNEW_NONCOMP_STICKY_FLAGS_EN
  logic                clear_flags_i;
  logic [4:0]          fflags_o;

  modport slave (
    input  result_i, status_i, extension_bit_i, class_mask_i, is_class_i, tag_i, aux_i,
    input  in_valid_i, flush_i, out_ready_i, clear_flags_i,
    output in_ready_o, result_o, status_o, extension_bit_o, tag_o, aux_o, out_valid_o,
    output busy_o, fflags_o
  );

  modport master (
    output result_i, status_i, extension_bit_i, class_mask_i, is_class_i, tag_i, aux_i,
    output in_valid_i, flush_i, out_ready_i, clear_flags_i,
    input  in_ready_o, result_o, status_o, extension_bit_o, tag_o, aux_o, out_valid_o,
    input  busy_o, fflags_o
  );
`else
  modport slave (
    input  result_i, status_i, extension_bit_i, class_mask_i, is_class_i, tag_i, aux_i,
    input  in_valid_i, flush_i, out_ready_i,
    output in_ready_o, result_o, status_o, extension_bit_o, tag_o, aux_o, out_valid_o,
    output busy_o
  );

  modport master (
    output result_i, status_i, extension_bit_i, class_mask_i, is_class_i, tag_i, aux_i,
    output in_valid_i, flush_i, out_ready_i,
    input  in_ready_o, result_o, status_o, extension_bit_o, tag_o, aux_o, out_valid_o,
    input  busy_o
  );
`endif
endinterface

// File: rtl/fpnew_noncomp_outpipe.sv
// Retirement stage for the non-computational FP unit: classify-mask merge plus a flushable valid/ready pipe.
// Optional macro FPNEW_NONCOMP_STICKY_FLAGS_EN adds a sticky accumulator of retired status flags.
module fpnew_noncomp_outpipe #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned NumPipeRegs = 1,
  parameter int unsigned TagWidth    = 1,
  parameter int unsigned AuxWidth    = 1
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  fpnew_noncomp_outpipe_if.slave  io
);

  typedef struct packed {
    logic [WIDTH-1:0]    result;
    logic [4:0]          status;
    logic                ext;
    logic [TagWidth-1:0] tag;
    logic [AuxWidth-1:0] aux;
  } payload_t;

  if ((WIDTH < 16) || (WIDTH > 64)) begin : g_width_chk
    $error("fpnew_noncomp_outpipe: WIDTH must lie in 16..64");
  end

  // A classify op carries only its mask; flags and the NaN-box bit are meaningless for it.
  function automatic payload_t merge_payload(
    input logic [WIDTH-1:0]    result,
    input logic [4:0]          status,
    input logic                ext,
    input logic [9:0]          class_mask,
    input logic                is_class,
    input logic [TagWidth-1:0] tag,
    input logic [AuxWidth-1:0] aux
  );
    payload_t p;
    p.tag = tag;
    p.aux = aux;
    if (is_class) begin
      p.result = {{(WIDTH-10){1'b0}}, class_mask};
      p.status = 5'b00000;
      p.ext    = 1'b0;
    end else begin
      p.result = result;
      p.status = status;
      p.ext    = ext;
    end
    return p;
  endfunction

  payload_t merged_s;
  payload_t out_s;
  logic     out_valid_s;
  logic     in_ready_s;
  logic     busy_s;

  // Merge the upstream result with the classify mask ahead of the first stage.
  always_comb begin
    merged_s = merge_payload(io.result_i, io.status_i, io.extension_bit_i, io.class_mask_i,
                             io.is_class_i, io.tag_i, io.aux_i);
  end

  if (NumPipeRegs == 0) begin : g_bypass
    assign out_s       = merged_s;
    assign out_valid_s = io.in_valid_i;
    assign in_ready_s  = io.out_ready_i;
    assign busy_s      = 1'b0;
  end else begin : g_pipe
    localparam int N = int'(NumPipeRegs);

    logic [N-1:0] valid_q;
    logic [N-1:0] valid_d;
    payload_t     data_q [N];
    payload_t     data_d [N];
    logic [N:0]   ready_s;
    logic [N-1:0] valid_in_s;
    payload_t     data_in_s [N];

    // Backward ready chain: a stage accepts when it is empty or its occupant moves on.
    always_comb begin
      ready_s    = '0;
      ready_s[N] = io.out_ready_i;
      for (int k = N - 1; k >= 0; k--) begin
        ready_s[k] = ready_s[k+1] | ~valid_q[k];
      end
    end

    // Feed of each stage: the merged input for the first, the previous stage otherwise.
    always_comb begin
      valid_in_s   = '0;
      valid_in_s[0] = io.in_valid_i;
      data_in_s[0]  = merged_s;
      for (int k = 1; k < N; k++) begin
        valid_in_s[k] = valid_q[k-1];
        data_in_s[k]  = data_q[k-1];
      end
    end

    // Next state of every stage; flush kills validity but leaves the data registers alone.
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      for (int k = 0; k < N; k++) begin
        if (io.flush_i) begin
          valid_d[k] = 1'b0;
        end else if (ready_s[k]) begin
          valid_d[k] = valid_in_s[k];
        end else begin
          valid_d[k] = valid_q[k];
        end
        if (ready_s[k] && valid_in_s[k]) begin
          data_d[k] = data_in_s[k];
        end else begin
          data_d[k] = data_q[k];
        end
      end
    end

    // Stage registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= '0;
        for (int k = 0; k < N; k++) begin
          data_q[k] <= '0;
        end
      end else begin
        valid_q <= valid_d;
        for (int k = 0; k < N; k++) begin
          data_q[k] <= data_d[k];
        end
      end
    end

    assign out_s       = data_q[N-1];
    assign out_valid_s = valid_q[N-1];
    assign in_ready_s  = ready_s[0];
    assign busy_s      = |valid_q;
  end

  assign io.result_o        = out_s.result;
  assign io.status_o        = out_s.status;
  assign io.extension_bit_o = out_s.ext;
  assign io.tag_o           = out_s.tag;
  assign io.aux_o           = out_s.aux;
  assign io.out_valid_o     = out_valid_s;
  assign io.in_ready_o      = in_ready_s;
  assign io.busy_o          = busy_s;

`ifdef FPNEW_NONCOMP_STICKY_FLAGS_EN
  logic [4:0] fflags_q;
  logic [4:0] fflags_d;
  logic       xfer_s;

  // A clear that coincides with a retirement keeps that retirement's flags.
  always_comb begin
    xfer_s = out_valid_s & io.out_ready_i;
    if (io.clear_flags_i) begin
      if (xfer_s) begin
        fflags_d = out_s.status;
      end else begin
        fflags_d = 5'b00000;
      end
    end else if (xfer_s) begin
      fflags_d = fflags_q | out_s.status;
    end else begin
      fflags_d = fflags_q;
    end
  end

  // Sticky flag register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fflags_q <= 5'b00000;
    end else begin
      fflags_q <= fflags_d;
    end
  end

  assign io.fflags_o = fflags_q;
`endif

endmodule

// File: tb/tb_fpnew_noncomp_outpipe.sv
// Bench for fpnew_noncomp_outpipe: a 2-stage and a pass-through instance driven by the same stimulus.
module tb_fpnew_noncomp_outpipe;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  st;
    logic        ext;
    logic [3:0]  tag;
    logic [2:0]  aux;
    int          t;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] result_in;
  logic [4:0]  status_in;
  logic        ext_in;
  logic [9:0]  mask_in;
  logic        is_class;
  logic [3:0]  tag_in;
  logic [2:0]  aux_in;
  logic        in_valid;
  logic        out_ready;
  logic        flush;
  logic        clear_flags;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  op_t  q[$];
  logic m_in_ready;
  logic [4:0] sticky_m;

  always #5 clk = ~clk;

  fpnew_noncomp_outpipe_if #(.WIDTH(32), .TagWidth(4), .AuxWidth(3)) if_p2 ();
  fpnew_noncomp_outpipe_if #(.WIDTH(32), .TagWidth(4), .AuxWidth(3)) if_p0 ();

  assign if_p2.result_i = result_in;        assign if_p0.result_i = result_in;
  assign if_p2.status_i = status_in;        assign if_p0.status_i = status_in;
  assign if_p2.extension_bit_i = ext_in;    assign if_p0.extension_bit_i = ext_in;
  assign if_p2.class_mask_i = mask_in;      assign if_p0.class_mask_i = mask_in;
  assign if_p2.is_class_i = is_class;       assign if_p0.is_class_i = is_class;
  assign if_p2.tag_i = tag_in;              assign if_p0.tag_i = tag_in;
  assign if_p2.aux_i = aux_in;              assign if_p0.aux_i = aux_in;
  assign if_p2.in_valid_i = in_valid;       assign if_p0.in_valid_i = in_valid;
  assign if_p2.out_ready_i = out_ready;     assign if_p0.out_ready_i = out_ready;
  assign if_p2.flush_i = flush;             assign if_p0.flush_i = flush;
`ifdef FPNEW_NONCOMP_STICKY_FLAGS_EN
  assign if_p2.clear_flags_i = clear_flags; assign if_p0.clear_flags_i = clear_flags;
`endif

  fpnew_noncomp_outpipe #(.WIDTH(32), .NumPipeRegs(2), .TagWidth(4), .AuxWidth(3)) u_p2 (
    .clk_i(clk), .rst_ni(rst_ni), .io(if_p2));
  fpnew_noncomp_outpipe #(.WIDTH(32), .NumPipeRegs(0), .TagWidth(4), .AuxWidth(3)) u_p0 (
    .clk_i(clk), .rst_ni(rst_ni), .io(if_p0));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference merge: a classify op yields its mask zero-extended, with no flags and no ext bit.
  function automatic op_t make_op();
    op_t o;
    o.tag = tag_in;
    o.aux = aux_in;
    o.t   = cyc;
    if (is_class) begin
      o.res = 32'(mask_in);
      o.st  = 5'd0;
      o.ext = 1'b0;
    end else begin
      o.res = result_in;
      o.st  = status_in;
      o.ext = ext_in;
    end
    return o;
  endfunction

  task automatic set_op(input logic [31:0] res, input logic [4:0] st, input logic ext,
                        input logic [9:0] mask, input logic cls, input logic [3:0] tag,
                        input logic [2:0] aux);
    result_in = res; status_in = st; ext_in = ext; mask_in = mask;
    is_class = cls; tag_in = tag; aux_in = aux;
  endtask

  // Model: ops retire in order; the oldest in-flight op shows at the output once it is 2 cycles old,
  // and the pipe refuses input only when it holds 2 ops and the consumer stalls.
  task automatic sample();
    op_t        cur;
    logic       exp_v;
    logic       xfer;
    logic [4:0] xst;
    @(negedge clk);
    cur        = make_op();
    exp_v      = (q.size() > 0) && ((cyc - q[0].t) >= 2);
    m_in_ready = out_ready || (q.size() < 2);
    check("p2_out_valid", 64'(if_p2.out_valid_o), 64'(exp_v));
    check("p2_in_ready", 64'(if_p2.in_ready_o), 64'(m_in_ready));
    check("p2_busy", 64'(if_p2.busy_o), 64'(q.size() > 0));
    if (exp_v) begin
      check("p2_result", 64'(if_p2.result_o), 64'(q[0].res));
      check("p2_status", 64'(if_p2.status_o), 64'(q[0].st));
      check("p2_ext", 64'(if_p2.extension_bit_o), 64'(q[0].ext));
      check("p2_tag", 64'(if_p2.tag_o), 64'(q[0].tag));
      check("p2_aux", 64'(if_p2.aux_o), 64'(q[0].aux));
    end
    check("p0_out_valid", 64'(if_p0.out_valid_o), 64'(in_valid));
    check("p0_in_ready", 64'(if_p0.in_ready_o), 64'(out_ready));
    check("p0_busy", 64'(if_p0.busy_o), 64'(1'b0));
    check("p0_result", 64'(if_p0.result_o), 64'(cur.res));
    check("p0_status", 64'(if_p0.status_o), 64'(cur.st));
    check("p0_ext", 64'(if_p0.extension_bit_o), 64'(cur.ext));
    check("p0_tag", 64'(if_p0.tag_o), 64'(cur.tag));
    check("p0_aux", 64'(if_p0.aux_o), 64'(cur.aux));
    xfer = exp_v && out_ready;
    xst  = exp_v ? q[0].st : 5'd0;
`ifdef FPNEW_NONCOMP_STICKY_FLAGS_EN
    check("p2_fflags", 64'(if_p2.fflags_o), 64'(sticky_m));
`endif
    if (clear_flags) sticky_m = xfer ? xst : 5'd0;
    else if (xfer) sticky_m = sticky_m | xst;
    if (xfer) void'(q.pop_front());
    if (in_valid && m_in_ready) q.push_back(cur);
    if (flush) q.delete();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  initial begin
    rst_ni = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; clear_flags = 1'b0;
    sticky_m = 5'd0; m_in_ready = 1'b1;
    set_op(32'hDEAD_BEEF, 5'b11111, 1'b1, 10'h001, 1'b0, 4'hF, 3'h7);
    @(negedge clk);
    check("rst_out_valid", 64'(if_p2.out_valid_o), 64'(1'b0));
    check("rst_result", 64'(if_p2.result_o), 64'(0));
    check("rst_status", 64'(if_p2.status_o), 64'(0));
    check("rst_ext", 64'(if_p2.extension_bit_o), 64'(0));
    check("rst_tag", 64'(if_p2.tag_o), 64'(0));
    check("rst_aux", 64'(if_p2.aux_o), 64'(0));
    check("rst_busy", 64'(if_p2.busy_o), 64'(0));
    check("rst_in_ready", 64'(if_p2.in_ready_o), 64'(1'b1));
    @(posedge clk); #1;
    rst_ni = 1'b1;
    cyc = 0;

    // Single op through the 2-stage pipe.
    out_ready = 1'b1;
    set_op(32'h3F80_0000, 5'd0, 1'b1, 10'h000, 1'b0, 4'h1, 3'h2);
    in_valid = 1'b1; step();
    in_valid = 1'b0; sample();
    check("single_busy_c1", 64'(if_p2.busy_o), 64'(1'b1));
    advance(); sample();
    check("single_valid_c2", 64'(if_p2.out_valid_o), 64'(1'b1));
    check("single_result_c2", 64'(if_p2.result_o), 64'(32'h3F80_0000));
    check("single_tag_c2", 64'(if_p2.tag_o), 64'(4'h1));
    check("single_busy_c2", 64'(if_p2.busy_o), 64'(1'b1));
    advance(); sample();
    check("single_valid_c3", 64'(if_p2.out_valid_o), 64'(1'b0));
    advance();

    // Classify merge.
    set_op(32'h7FC0_1234, 5'b10000, 1'b1, 10'h200, 1'b1, 4'h3, 3'h5);
    in_valid = 1'b1; sample();
    check("class_p0_result", 64'(if_p0.result_o), 64'(32'h0000_0200));
    check("class_p0_status", 64'(if_p0.status_o), 64'(5'd0));
    check("class_p0_ext", 64'(if_p0.extension_bit_o), 64'(1'b0));
    advance();
    in_valid = 1'b0; step(); sample();
    check("class_p2_result", 64'(if_p2.result_o), 64'(32'h0000_0200));
    check("class_p2_status", 64'(if_p2.status_o), 64'(5'd0));
    check("class_p2_ext", 64'(if_p2.extension_bit_o), 64'(1'b0));
    advance(); step();

    // Backpressure: four ops, consumer stalled for the first three cycles.
    begin
      int idx = 0;
      for (int k = 0; k < 12; k++) begin
        in_valid = (idx < 4);
        set_op(32'h4000_0000 + 32'(idx), 5'(idx), 1'b0, 10'h000, 1'b0, 4'(idx), 3'(idx));
        out_ready = (k >= 3);
        sample();
        if (k == 2) begin
          check("bp_in_ready_full", 64'(if_p2.in_ready_o), 64'(1'b0));
          check("bp_out_valid_held", 64'(if_p2.out_valid_o), 64'(1'b1));
          check("bp_result_held", 64'(if_p2.result_o), 64'(32'h4000_0000));
        end
        if (k == 3) check("bp_result_stable", 64'(if_p2.result_o), 64'(32'h4000_0000));
        if (in_valid && m_in_ready) idx++;
        advance();
      end
    end

    // Flush with two ops in flight and a third presented.
    out_ready = 1'b0;
    set_op(32'h1111_1111, 5'd1, 1'b0, 10'h000, 1'b0, 4'h1, 3'h1); in_valid = 1'b1; step();
    set_op(32'h2222_2222, 5'd2, 1'b0, 10'h000, 1'b0, 4'h2, 3'h2); step();
    set_op(32'h3333_3333, 5'd4, 1'b0, 10'h000, 1'b0, 4'h3, 3'h3); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0; sample();
    check("flush_out_valid", 64'(if_p2.out_valid_o), 64'(1'b0));
    check("flush_busy", 64'(if_p2.busy_o), 64'(1'b0));
    advance();
    // An op accepted in the flush cycle is dropped too.
    set_op(32'h4444_4444, 5'd8, 1'b0, 10'h000, 1'b0, 4'h4, 3'h4); in_valid = 1'b1; step();
    set_op(32'h5555_5555, 5'd16, 1'b0, 10'h000, 1'b0, 4'h5, 3'h5); flush = 1'b1; sample();
    check("flush_accept_ready", 64'(if_p2.in_ready_o), 64'(1'b1));
    advance();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sample();
    check("flush2_busy", 64'(if_p2.busy_o), 64'(1'b0));
    advance();
    for (int k = 0; k < 4; k++) step();

    // Pass-through instance under backpressure.
    out_ready = 1'b0; in_valid = 1'b1;
    set_op(32'hC0DE_0001, 5'b00100, 1'b1, 10'h000, 1'b0, 4'h6, 3'h6);
    sample();
    check("n0_out_valid", 64'(if_p0.out_valid_o), 64'(1'b1));
    check("n0_in_ready", 64'(if_p0.in_ready_o), 64'(1'b0));
    check("n0_busy", 64'(if_p0.busy_o), 64'(1'b0));
    advance();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();

`ifdef FPNEW_NONCOMP_STICKY_FLAGS_EN
    clear_flags = 1'b1; step(); clear_flags = 1'b0;
    set_op(32'h0, 5'b10000, 1'b0, 10'h000, 1'b0, 4'h0, 3'h0); in_valid = 1'b1; step();
    set_op(32'h0, 5'b00001, 1'b0, 10'h000, 1'b0, 4'h0, 3'h0); step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    sample();
    check("sticky_nv_nx", 64'(if_p2.fflags_o), 64'(5'b10001));
    advance();
    set_op(32'h0, 5'b01000, 1'b0, 10'h000, 1'b0, 4'h0, 3'h0); in_valid = 1'b1; step();
    in_valid = 1'b0; step();
    clear_flags = 1'b1; step();
    clear_flags = 1'b0; sample();
    check("sticky_clear_dz", 64'(if_p2.fflags_o), 64'(5'b01000));
    advance();
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      set_op($urandom, 5'($urandom), 1'($urandom), 10'(32'd1 << $urandom_range(9, 0)),
             ($urandom_range(3, 0) == 0), 4'($urandom), 3'($urandom));
      in_valid    = ($urandom_range(3, 0) != 0);
      out_ready   = ($urandom_range(3, 0) != 0);
      flush       = ($urandom_range(39, 0) == 0);
      clear_flags = ($urandom_range(29, 0) == 0);
      step();
    end
    flush = 1'b0; clear_flags = 1'b0;

    // Reset in the middle of traffic drops everything at once.
    out_ready = 1'b0; in_valid = 1'b1;
    set_op(32'hABCD_0001, 5'd3, 1'b1, 10'h000, 1'b0, 4'h7, 3'h1); step();
    set_op(32'hABCD_0002, 5'd5, 1'b1, 10'h000, 1'b0, 4'h8, 3'h2); step();
    in_valid = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("midrst_out_valid", 64'(if_p2.out_valid_o), 64'(1'b0));
    check("midrst_busy", 64'(if_p2.busy_o), 64'(1'b0));
    check("midrst_in_ready", 64'(if_p2.in_ready_o), 64'(1'b1));
    check("midrst_result", 64'(if_p2.result_o), 64'(0));
    q.delete();
    sticky_m = 5'd0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    cyc++;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpnew_noncomp_outpipe.md
Name: fpnew_noncomp_outpipe

Overview:
- Output retirement stage placed directly downstream of the non-computational FP unit (SGNJ/MINMAX/CMP/CLASSIFY).
- Merges the classification mask into the result word and registers result, status, extension bit, tag and aux through a configurable-depth valid/ready pipeline.
- Supports flush and reports busy, restoring the pipelining and busy indication the combinational unit lacks.

Parameters:
- WIDTH, 32: FP format width of result; legal range 16..64 (elaboration error otherwise).
- NumPipeRegs, 1: number of register stages; 0 = combinational pass-through.
- TagWidth, 1: width of tag sideband.
- AuxWidth, 1: width of aux sideband.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- result_i  in  WIDTH  result from the non-computational unit.
- status_i  in  5  flags {NV,DZ,OF,UF,NX}.
- extension_bit_i  in  1  NaN-box / sign-extension bit.
- class_mask_i  in  10  one-hot classify mask.
- is_class_i  in  1  op was CLASSIFY.
- tag_i  in  TagWidth  tag sideband.
- aux_i  in  AuxWidth  aux sideband.
- in_valid_i  in  1  upstream valid.
- in_ready_o  out  1  ready to upstream.
- flush_i  in  1  kill all in-flight ops.
- result_o  out  WIDTH  merged result.
- status_o  out  5  flags.
- extension_bit_o  out  1  extension bit.
- tag_o  out  TagWidth  tag.
- aux_o  out  AuxWidth  aux.
- out_valid_o  out  1  downstream valid.
- out_ready_i  in  1  downstream ready.
- busy_o  out  1  any stage holds a valid op.

Behaviour:
- Merge (combinational, before stage 0):
  - is_class_i=1: merged result = {WIDTH-10 zeros, class_mask_i}, status forced to 0, extension bit forced to 0.
  - is_class_i=0: result_i, status_i and extension_bit_i pass unchanged.
- Pipeline: stages 1..N, N=NumPipeRegs. Each stage k holds valid_q[k] and a data register (merged result, status, ext, tag, aux).
- Ready chain:
  - ready[N] = out_ready_i.
  - ready[k-1] = ready[k] | ~valid_q[k].
  - in_ready_o = ready[0].
- Stage k loads data from stage k-1 when ready[k-1]=1. On load, valid_q[k] <= valid[k-1]; stage 0 valid is in_valid_i. Data registers load only when ready and the incoming valid is 1.
- Outputs come from stage N: out_valid_o = valid_q[N]; data outputs = stage N registers.
- Latency: N cycles from the in_valid_i & in_ready_o handshake to out_valid_o with no backpressure. Throughput: 1 op/cycle.
- Backpressure: when out_valid_o=1 and out_ready_i=0, all stage-N outputs hold stable. Bubbles collapse: an empty stage accepts even while downstream stalls.
- Flush:
  - flush_i=1 clears every valid_q on the next edge; data registers are untouched.
  - An input accepted in the same cycle as flush is discarded.
  - in_ready_o is not gated by flush.
- busy_o = OR of all valid_q; constant 0 when N=0.
- Reset (async, rst_ni=0):
  - All valid_q and data registers = 0.
  - Outputs: out_valid_o=0, result_o=0, status_o=0, extension_bit_o=0, tag_o=0, aux_o=0, busy_o=0, in_ready_o=1.
- Reset asserted mid-operation drops in-flight ops immediately; no output handshake occurs for them.
- N=0:
  - All outputs combinational from the merged inputs.
  - out_valid_o = in_valid_i; in_ready_o = out_ready_i.
  - flush_i has no effect.

Optional Feature:
- Macro FPNEW_NONCOMP_STICKY_FLAGS_EN.
- When defined, adds ports clear_flags_i (in, 1) and fflags_o (out, 5), plus a 5-bit sticky register.
  - Each cycle with out_valid_o & out_ready_i, the register ORs in status_o.
  - clear_flags_i=1 zeroes it; if a transfer occurs in the same cycle, the register loads that transfer's status_o, so the transfer's flags are kept.
  - fflags_o is the register value; reset value 0.
  - Flushed ops never contribute.
- When undefined, these ports and the register do not exist.

Test Plan:
- N=2, single op: result_i=0x3F800000, status_i=0, tag_i=1 accepted at cycle 0 -> out_valid_o=1 at cycle 2 with result_o=0x3F800000, tag_o=1; busy_o=1 in cycles 1..2.
- Classify merge: is_class_i=1, class_mask_i=0x200 (QNAN), status_i=5'b10000 -> result_o=0x00000200, status_o=0, extension_bit_o=0.
- Backpressure, N=2: stream 4 ops, out_ready_i=0 for 3 cycles -> in_ready_o=0 once both stages are full; out_valid_o stays 1 with result_o stable; all 4 ops exit in order with none lost or duplicated.
- Flush, N=2: two ops in flight, flush_i pulsed together with a third input -> next cycle out_valid_o=0, busy_o=0; none of the 3 ops ever appear at the output.
- N=0: in_valid_i=1, out_ready_i=0 -> out_valid_o=1, in_ready_o=0 in the same cycle; busy_o=0.
- Sticky flags (macro defined): transfer ops with status NV then NX -> fflags_o=5'b10001. clear_flags_i in the same cycle as a DZ transfer -> fflags_o=5'b01000.
